// File: rtl/uart_word_io.sv
// ---------------------------------------------------------------------------
// uart_word_io
//
// Word-level front end for the byte-wide UART/AXI-lite adapter. Takes one
// command of 1..4 bytes from the CPU I/O unit and turns it into a sequence of
// single-byte requests towards the adapter, one outstanding at a time.
//   - Write: bytes are sent LSB first out of a shift register.
//   - Read : bytes are collected into rsp_rdata, zero-extended to 32 bits.
//
// Optional feature (compile-time macro UART_WORD_RX_TIMEOUT_EN):
//   Per-byte receive timeout. When a byte does not arrive within RX_TIMEOUT
//   cycles of entering RX_WAIT, the command completes with rsp_timeout=1 and
//   rsp_rdata keeps the bytes received so far. The adapter may still be busy
//   at that point, so the system must pulse rstn before issuing more traffic.
//   Without the macro, rsp_timeout is constant 0 and RX_WAIT waits forever.
//
// Parameters:
//   RX_TIMEOUT  cycles allowed per received byte (timeout build only), >= 2
//
// Ports:
//   clk, rstn     clock, synchronous active-low reset
//   cmd_*         command handshake; cmd_ready is high only in IDLE
//   rsp_valid     one-cycle completion pulse, qualified by rsp_timeout
//   rsp_rdata     received word; holds until the next accepted command
//   u_t_valid     one-cycle byte transmit request; u_t_data held until done
//   u_tx_done     adapter transmit-complete pulse
//   u_r_valid     one-cycle byte receive request
//   u_r_data      received byte, valid with u_rx_done
//   u_rx_done     adapter receive-complete pulse
//
// Every output is a flop. The output flops are loaded from the next-state
// decode, so each output lines up exactly with the state it belongs to.
// ---------------------------------------------------------------------------
module uart_word_io #(
    parameter int RX_TIMEOUT = 1048576
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_nbytes,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        u_t_valid,
    output logic [7:0]  u_t_data,
    input  logic        u_tx_done,
    output logic        u_r_valid,
    input  logic [7:0]  u_r_data,
    input  logic        u_rx_done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TX_ISSUE = 3'd1,
        TX_WAIT  = 3'd2,
        RX_ISSUE = 3'd3,
        RX_WAIT  = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t      state, state_nxt;

    // Command context. The direction of the command is carried by the state
    // encoding itself (TX_* vs RX_*), so no separate write flag is kept.
    logic [1:0]  nbytes, nbytes_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic [31:0] shift, shift_nxt;

    // Next values of the registered outputs.
    logic [31:0] rdata_nxt;
    logic [7:0]  t_data_nxt;
    logic        timeout_nxt;

    // High for the single RX_WAIT cycle in which the byte budget runs out.
    logic        rx_expired;

`ifdef UART_WORD_RX_TIMEOUT_EN
    // Counter value seen in the last allowed cycle: entering RX_WAIT with 0,
    // the DONE transition happens RX_TIMEOUT cycles after entry.
    localparam logic [20:0] TO_LAST = 21'(RX_TIMEOUT - 1);

    logic [20:0] to_cnt, to_cnt_nxt;

    // Zero in every non-RX_WAIT cycle, so the first RX_WAIT cycle sees 0.
    assign to_cnt_nxt = (state == RX_WAIT) ? to_cnt + 21'd1 : 21'd0;
    assign rx_expired = (state == RX_WAIT) && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt_nxt;
        end
    end
`else
    // Parameter only matters in the timeout build.
    logic unused_rx_timeout;
    assign unused_rx_timeout = ^RX_TIMEOUT;
    assign rx_expired        = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Next-state and datapath decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        nbytes_nxt  = nbytes;
        cnt_nxt     = cnt;
        shift_nxt   = shift;
        rdata_nxt   = rsp_rdata;
        t_data_nxt  = u_t_data;
        timeout_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    nbytes_nxt = cmd_nbytes;
                    cnt_nxt    = 2'd0;
                    shift_nxt  = cmd_wdata;
                    rdata_nxt  = '0;
                    state_nxt  = cmd_write ? TX_ISSUE : RX_ISSUE;
                end
            end

            TX_ISSUE: state_nxt = TX_WAIT;

            TX_WAIT: begin
                // Only u_tx_done is looked at here; a stray u_rx_done is
                // simply not decoded in this state.
                if (u_tx_done) begin
                    if (cnt == nbytes) begin
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt   = cnt + 2'd1;
                        shift_nxt = {8'h00, shift[31:8]};
                        state_nxt = TX_ISSUE;
                    end
                end
            end

            RX_ISSUE: state_nxt = RX_WAIT;

            RX_WAIT: begin
                // A byte arriving in the expiry cycle takes priority.
                if (u_rx_done) begin
                    rdata_nxt[{cnt, 3'b000} +: 8] = u_r_data;
                    if (cnt == nbytes) begin
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt   = cnt + 2'd1;
                        state_nxt = RX_ISSUE;
                    end
                end else if (rx_expired) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = DONE;
                end
            end

            DONE: state_nxt = IDLE;

            default: state_nxt = IDLE;
        endcase

        // The transmit byte is loaded whenever a TX_ISSUE is entered and is
        // otherwise held, which keeps it stable through TX_WAIT.
        if (state_nxt == TX_ISSUE) begin
            t_data_nxt = shift_nxt[7:0];
        end
    end

    // -----------------------------------------------------------------------
    // State register and context
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= IDLE;
            nbytes <= 2'd0;
            cnt    <= 2'd0;
            shift  <= '0;
        end else begin
            state  <= state_nxt;
            nbytes <= nbytes_nxt;
            cnt    <= cnt_nxt;
            shift  <= shift_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Registered outputs, decoded from the next state so that request and
    // response pulses coincide with their one-cycle states.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            u_t_valid   <= 1'b0;
            u_t_data    <= '0;
            u_r_valid   <= 1'b0;
        end else begin
            cmd_ready   <= (state_nxt == IDLE);
            rsp_valid   <= (state_nxt == DONE);
            rsp_rdata   <= rdata_nxt;
            rsp_timeout <= timeout_nxt;
            u_t_valid   <= (state_nxt == TX_ISSUE);
            u_t_data    <= t_data_nxt;
            u_r_valid   <= (state_nxt == RX_ISSUE);
        end
    end

endmodule

// File: tb/tb_uart_word_io.sv
// ---------------------------------------------------------------------------
// tb_uart_word_io
//
// Bench for uart_word_io. A behavioural adapter model answers byte requests
// after a programmable delay; expected transmit bytes and responses are
// queued when a command is driven and popped when the DUT produces them.
// Inputs are driven 1 time unit after the rising edge, DUT outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_word_io;

    localparam int RXTO = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [1:0]  cmd_nbytes = 2'd0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        u_t_valid;
    logic [7:0]  u_t_data;
    logic        u_tx_done = 1'b0;
    logic        u_r_valid;
    logic [7:0]  u_r_data = 8'h00;
    logic        u_rx_done = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        timeout;
    } rsp_t;

    rsp_t       exp_rsp[$];
    logic [7:0] exp_tx[$];
    logic [7:0] rx_bytes[$];
    rsp_t       e;

    // Adapter model controls and observation counters.
    int         tx_delay = 1;
    int         rx_delay = 1;
    bit         rx_mute = 1'b0;
    int         tx_cnt = 0;
    int         rx_cnt = 0;
    logic [7:0] tx_hold = 8'h00;
    int         inj_tx_at = -1;
    int         inj_rx_at = -1;
    int         tv_cnt = 0;
    int         rv_cnt = 0;
    int         rsp_cnt = 0;
    int         last_tv_cyc = -1;
    int         last_rsp_cyc = -1;

    uart_word_io #(.RX_TIMEOUT(RXTO)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_nbytes (cmd_nbytes),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .u_t_valid  (u_t_valid),
        .u_t_data   (u_t_data),
        .u_tx_done  (u_tx_done),
        .u_r_valid  (u_r_valid),
        .u_r_data   (u_r_data),
        .u_rx_done  (u_rx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Adapter model plus transmit/response scoreboards.
    always @(negedge clk) begin
        u_tx_done = 1'b0;
        u_rx_done = 1'b0;
        if (!rstn) begin
            tx_cnt = 0;
            rx_cnt = 0;
            rx_bytes.delete();
        end else begin
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    u_tx_done = 1'b1;
                    checks++;
                    if (u_t_data !== tx_hold) begin
                        errors++;
                        $display("FAIL tx_hold got %h want %h", u_t_data, tx_hold);
                    end
                end
            end
            if (rx_cnt > 0) begin
                rx_cnt--;
                if (rx_cnt == 0) begin
                    u_rx_done = 1'b1;
                    if (rx_bytes.size() > 0) u_r_data = rx_bytes.pop_front();
                    else u_r_data = 8'h00;
                end
            end
            if (cyc == inj_tx_at) u_tx_done = 1'b1;
            if (cyc == inj_rx_at) begin
                u_rx_done = 1'b1;
                u_r_data  = 8'hEE;
            end
            if (u_t_valid) begin
                tv_cnt++;
                last_tv_cyc = cyc;
                tx_cnt  = tx_delay;
                tx_hold = u_t_data;
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected got %h want none", u_t_data);
                end else begin
                    tx_hold = exp_tx.pop_front();
                    if (u_t_data !== tx_hold) begin
                        errors++;
                        $display("FAIL tx_byte got %h want %h", u_t_data, tx_hold);
                    end
                end
            end
            if (u_r_valid) begin
                rv_cnt++;
                if (!rx_mute) rx_cnt = rx_delay;
            end
            if (u_t_valid || u_r_valid) begin
                checks++;
                if (cmd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL req_with_ready got %b want 0", cmd_ready);
                end
            end
            if (rsp_valid) begin
                rsp_cnt++;
                last_rsp_cyc = cyc;
                checks++;
                if (exp_rsp.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected got %h/%b want none", rsp_rdata, rsp_timeout);
                end else begin
                    e = exp_rsp.pop_front();
                    if (rsp_rdata !== e.rdata || rsp_timeout !== e.timeout) begin
                        errors++;
                        $display("FAIL rsp_data got %h/%b want %h/%b",
                                 rsp_rdata, rsp_timeout, e.rdata, e.timeout);
                    end
                end
            end
        end
    end

    // Stimulus helpers (bounded waits; expiry is a failed comparison).
    task automatic send_cmd(input logic wr, input logic [1:0] nb,
                            input logic [31:0] wd, output int acc);
        acc = -1;
        @(posedge clk); #1;
        cmd_valid  = 1'b1;
        cmd_write  = wr;
        cmd_nbytes = nb;
        cmd_wdata  = wd;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (acc < 0) begin
            errors++;
            $display("FAIL cmd_accept got none want accept within 50 cycles");
        end
    endtask

    task automatic wait_rsp(input int n0, input int limit);
        int k = 0;
        while (rsp_cnt <= n0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (rsp_cnt <= n0) begin
            errors++;
            $display("FAIL rsp_wait got none want rsp within %0d cycles", limit);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata got %h want 0", rsp_rdata); end
        if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL rst_rsp_timeout got %b want 0", rsp_timeout); end
        if (u_t_valid !== 1'b0) begin errors++; $display("FAIL rst_t_valid got %b want 0", u_t_valid); end
        if (u_r_valid !== 1'b0) begin errors++; $display("FAIL rst_r_valid got %b want 0", u_r_valid); end
        if (u_t_data !== 8'h0) begin errors++; $display("FAIL rst_t_data got %h want 0", u_t_data); end
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_write4();
        int acc, n0, t0;
        tx_delay = 3;
        n0 = rsp_cnt;
        t0 = tv_cnt;
        exp_tx.push_back(8'h11); exp_tx.push_back(8'h22);
        exp_tx.push_back(8'h33); exp_tx.push_back(8'h44);
        exp_rsp.push_back('{32'h0, 1'b0});
        send_cmd(1'b1, 2'd3, 32'h44332211, acc);
        wait_rsp(n0, 100);
        checks += 4;
        if (tv_cnt - t0 != 4) begin errors++; $display("FAIL wr4_tv_pulses got %0d want 4", tv_cnt - t0); end
        if (rsp_cnt - n0 != 1) begin errors++; $display("FAIL wr4_rsp_pulses got %0d want 1", rsp_cnt - n0); end
        if (exp_tx.size() != 0) begin errors++; $display("FAIL wr4_tx_left got %0d want 0", exp_tx.size()); end
        if (last_rsp_cyc != acc + 17) begin errors++; $display("FAIL wr4_rsp_cycle got %0d want %0d", last_rsp_cyc, acc + 17); end
    endtask

    task automatic test_read2();
        int acc, n0, r0;
        rx_delay = 2;
        n0 = rsp_cnt;
        r0 = rv_cnt;
        rx_bytes.push_back(8'hAB); rx_bytes.push_back(8'hCD);
        exp_rsp.push_back('{32'h0000CDAB, 1'b0});
        send_cmd(1'b0, 2'd1, 32'hFFFFFFFF, acc);
        inj_tx_at = acc + 2;  // stray transmit done while in RX_WAIT
        wait_rsp(n0, 100);
        checks += 3;
        if (rv_cnt - r0 != 2) begin errors++; $display("FAIL rd2_rv_pulses got %0d want 2", rv_cnt - r0); end
        if (rsp_cnt - n0 != 1) begin errors++; $display("FAIL rd2_rsp_pulses got %0d want 1", rsp_cnt - n0); end
        if (last_rsp_cyc != acc + 7) begin errors++; $display("FAIL rd2_rsp_cycle got %0d want %0d", last_rsp_cyc, acc + 7); end
    endtask

    task automatic test_stray();
        int acc, n0, t0, r0;
        n0 = rsp_cnt;
        t0 = tv_cnt;
        r0 = rv_cnt;
        @(posedge clk); #1;
        inj_tx_at = cyc + 1;
        inj_rx_at = cyc + 2;
        repeat (5) @(negedge clk);
        checks += 4;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_stray_ready got %b want 1", cmd_ready); end
        if (rsp_rdata !== 32'h0000CDAB) begin errors++; $display("FAIL idle_stray_rdata got %h want 0000cdab", rsp_rdata); end
        if (rsp_cnt != n0) begin errors++; $display("FAIL idle_stray_rsp got %0d want %0d", rsp_cnt, n0); end
        if (tv_cnt != t0 || rv_cnt != r0) begin errors++; $display("FAIL idle_stray_req got %0d/%0d want %0d/%0d", tv_cnt, rv_cnt, t0, r0); end
        tx_delay = 4;
        exp_tx.push_back(8'hEF); exp_tx.push_back(8'hBE);
        exp_rsp.push_back('{32'h0, 1'b0});
        send_cmd(1'b1, 2'd1, 32'h0000BEEF, acc);
        inj_rx_at = acc + 2;  // stray receive done while in TX_WAIT
        wait_rsp(n0, 100);
        checks += 3;
        if (rv_cnt != r0) begin errors++; $display("FAIL txw_stray_rv got %0d want %0d", rv_cnt, r0); end
        if (rsp_cnt - n0 != 1) begin errors++; $display("FAIL txw_stray_rsp got %0d want 1", rsp_cnt - n0); end
        if (last_rsp_cyc != acc + 11) begin errors++; $display("FAIL txw_rsp_cycle got %0d want %0d", last_rsp_cyc, acc + 11); end
    endtask

    task automatic test_back_to_back();
        int n, r, n0, t0, tv1, rs1;
        n  = -1;
        r  = -1;
        tx_delay = 1;
        n0 = rsp_cnt;
        t0 = tv_cnt;
        exp_tx.push_back(8'h5A); exp_tx.push_back(8'h5A);
        exp_rsp.push_back('{32'h0, 1'b0});
        exp_rsp.push_back('{32'h0, 1'b0});
        @(posedge clk); #1;
        cmd_valid  = 1'b1;
        cmd_write  = 1'b1;
        cmd_nbytes = 2'd0;
        cmd_wdata  = 32'h0000005A;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin n = cyc; break; end
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin r = cyc; break; end
        end
        tv1 = last_tv_cyc;
        rs1 = last_rsp_cyc;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_rsp(n0 + 1, 50);
        checks += 6;
        if (r != n + 4) begin errors++; $display("FAIL b2b_ready_cycle got %0d want %0d", r, n + 4); end
        if (tv1 != n + 1) begin errors++; $display("FAIL b2b_tv_cycle got %0d want %0d", tv1, n + 1); end
        if (rs1 != n + 3) begin errors++; $display("FAIL b2b_rsp_cycle got %0d want %0d", rs1, n + 3); end
        if (last_tv_cyc != r + 1) begin errors++; $display("FAIL b2b_second_tv got %0d want %0d", last_tv_cyc, r + 1); end
        if (tv_cnt - t0 != 2) begin errors++; $display("FAIL b2b_tv_pulses got %0d want 2", tv_cnt - t0); end
        if (rsp_cnt - n0 != 2) begin errors++; $display("FAIL b2b_rsp_pulses got %0d want 2", rsp_cnt - n0); end
    endtask

    task automatic test_reset_mid();
        int acc, n0, r0, k;
        rx_delay = 4;
        n0 = rsp_cnt;
        r0 = rv_cnt;
        k  = 0;
        rx_bytes.push_back(8'h01); rx_bytes.push_back(8'h02);
        rx_bytes.push_back(8'h03); rx_bytes.push_back(8'h04);
        send_cmd(1'b0, 2'd3, 32'h0, acc);
        while (rv_cnt < r0 + 3 && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks += 2;
        if (rv_cnt < r0 + 3) begin errors++; $display("FAIL midrst_third_req got %0d want %0d", rv_cnt - r0, 3); end
        if (rsp_rdata !== 32'h00000201) begin errors++; $display("FAIL midrst_partial got %h want 00000201", rsp_rdata); end
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        checks += 7;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", cmd_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_rsp_valid got %b want 0", rsp_valid); end
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata got %h want 0", rsp_rdata); end
        if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL midrst_timeout got %b want 0", rsp_timeout); end
        if (u_t_valid !== 1'b0) begin errors++; $display("FAIL midrst_t_valid got %b want 0", u_t_valid); end
        if (u_r_valid !== 1'b0) begin errors++; $display("FAIL midrst_r_valid got %b want 0", u_r_valid); end
        if (u_t_data !== 8'h0) begin errors++; $display("FAIL midrst_t_data got %h want 0", u_t_data); end
        rx_delay = 2;
        rx_bytes.push_back(8'h0A); rx_bytes.push_back(8'h0B); rx_bytes.push_back(8'h0C);
        exp_rsp.push_back('{32'h000C0B0A, 1'b0});
        send_cmd(1'b0, 2'd2, 32'h0, acc);
        wait_rsp(n0, 100);
        checks += 1;
        if (rsp_cnt - n0 != 1) begin errors++; $display("FAIL midrst_after_rsp got %0d want 1", rsp_cnt - n0); end
    endtask

`ifdef UART_WORD_RX_TIMEOUT_EN
    task automatic test_rx_timeout();
        int acc, n0;
        n0 = rsp_cnt;
        rx_mute = 1'b1;
        exp_rsp.push_back('{32'h0, 1'b1});
        send_cmd(1'b0, 2'd0, 32'h0, acc);
        wait_rsp(n0, 80);
        checks += 1;
        if (last_rsp_cyc != acc + 2 + RXTO) begin
            errors++;
            $display("FAIL rx_timeout_cycle got %0d want %0d", last_rsp_cyc, acc + 2 + RXTO);
        end
        rx_mute = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout got hang want finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_write4();
        test_read2();
        test_stray();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_WORD_RX_TIMEOUT_EN
        test_rx_timeout();
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (exp_rsp.size() != 0) begin
            errors++;
            $display("FAIL rsp_left got %0d want 0", exp_rsp.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
